julia_pixel_writer: RTL and testbench

- Downstream stage of the Julia pixel generator.
- Accepts the generator's pixel stream (pixel index + colour word) through a valid/ready handshake and buffers it in a small FIFO.
- Drains the FIFO as Avalon-MM master writes into the SDRAM frame buffer read by the pixel buffer.
- Reports frame completion so the CSR slave can expose status and re-arm the next frame.

---
 rtl/julia_pixel_writer.sv | 119 +++++++++++
 tb/tb_julia_pixel_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_writer.sv
// rtl/julia_pixel_writer.sv - Julia pixel stream to Avalon-MM frame-buffer writer
// Accepted pixels are buffered in a FIFO and drained as single-beat master writes.
module julia_pixel_writer #(
  parameter int                             MASTER_ADDRESSWIDTH = 32,
  parameter int                             DATAWIDTH           = 32,
  parameter int                             FIFO_DEPTH          = 16,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] BASE_ADDR           = 32'h08000000,
  parameter int                             NUM_PIXELS          = 307200,
  parameter int                             IDXWIDTH            = 19
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pix_valid,
  input  logic [IDXWIDTH-1:0]            pix_index,
  input  logic [DATAWIDTH-1:0]           pix_data,
  output logic                           pix_ready,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  input  logic                           master_waitrequest,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           err_range,
  output logic [IDXWIDTH:0]              pix_count
);

  localparam int                AW      = $clog2(FIFO_DEPTH);
  localparam logic [IDXWIDTH:0] NUM_PIX = (IDXWIDTH+1)'(NUM_PIXELS);
  localparam logic [AW:0]       PTR_ONE = 1;
  localparam logic [IDXWIDTH:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [AW:0]                    wr_ptr, rd_ptr;
  logic [MASTER_ADDRESSWIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATAWIDTH-1:0]           data_mem [FIFO_DEPTH];
  logic [MASTER_ADDRESSWIDTH-1:0] last_addr;
  logic [DATAWIDTH-1:0]           last_data;
  logic [MASTER_ADDRESSWIDTH-1:0] push_addr;

  logic fifo_empty, fifo_full;
  logic arm, accept, in_range, push, pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign arm       = (state == IDLE) && start;
  assign accept    = pix_valid && pix_ready;
  assign in_range  = ({1'b0, pix_index} < NUM_PIX);
  assign push      = accept && in_range;
  assign pop       = !fifo_empty && !master_waitrequest;
  assign push_addr = BASE_ADDR + (MASTER_ADDRESSWIDTH'(pix_index) << 2);

  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        pix_ready = !fifo_full && (pix_count < NUM_PIX);
        if (pix_count >= NUM_PIX) state_nxt = DRAIN;
      end
      DRAIN: if (fifo_empty) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pix_count <= '0;
      err_range <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        pix_count <= '0;
        err_range <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (accept) pix_count <= pix_count + CNT_ONE;
        if (accept && !in_range) err_range <= 1'b1;
      end
      // Remember the last written beat so the bus holds it while the FIFO is empty.
      if (pop) begin
        last_addr <= addr_mem[rd_ptr[AW-1:0]];
        last_data <= data_mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[AW-1:0]] <= push_addr;
      data_mem[wr_ptr[AW-1:0]] <= pix_data;
    end
  end

  assign master_write     = !fifo_empty;
  assign master_address   = fifo_empty ? last_addr : addr_mem[rd_ptr[AW-1:0]];
  assign master_writedata = fifo_empty ? last_data : data_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_julia_pixel_writer.sv
// tb/tb_julia_pixel_writer.sv - self-checking bench for julia_pixel_writer
// Small frame (8 pixels) and 4-deep FIFO so every corner is reached quickly.
module tb_julia_pixel_writer;

  localparam int          IW   = 4;
  localparam int          NP   = 8;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'h08000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, pix_valid, pix_ready;
  logic [IW-1:0] pix_index;
  logic [31:0]   pix_data, master_address, master_writedata;
  logic          master_write, master_waitrequest, busy, frame_done, err_range;
  logic [IW:0]   pix_count;

  julia_pixel_writer #(
    .MASTER_ADDRESSWIDTH(32), .DATAWIDTH(32), .FIFO_DEPTH(FD),
    .BASE_ADDR(BASE), .NUM_PIXELS(NP), .IDXWIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_index(pix_index), .pix_data(pix_data), .pix_ready(pix_ready),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_waitrequest(master_waitrequest),
    .busy(busy), .frame_done(frame_done), .err_range(err_range), .pix_count(pix_count)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   data;
    logic          exp_wr;
    logic [31:0]   exp_addr;
    logic          exp_err;
  } vec_t;

  vec_t        vt[16];
  int          idx3[8] = '{0, 9, 1, 2, 3, 4, 5, 6};
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_count, frame_dones;
  logic        exp_err, stall_prev;
  logic [31:0] prev_addr, prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe the handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (master_write === 1'b1) begin
      if (stall_prev) begin
        chk("stall_addr_hold", 64'(master_address), 64'(prev_addr));
        chk("stall_data_hold", 64'(master_writedata), 64'(prev_data));
      end
      if (master_waitrequest == 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", master_address, master_writedata);
        end else begin
          e = exp_q.pop_front();
          n_checks--;
          chk("write_addr_data", {master_address, master_writedata}, e);
        end
      end
    end
    stall_prev = (master_write === 1'b1) && master_waitrequest;
    prev_addr  = master_address;
    prev_data  = master_writedata;
    if (pix_valid && pix_ready === 1'b1) begin
      exp_count++;
      if (int'(pix_index) < NP) exp_q.push_back({BASE + (32'(pix_index) << 2), pix_data});
      else exp_err = 1'b1;
    end
    if (frame_done === 1'b1) frame_dones++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_count   = 0;
    exp_err     = 1'b0;
    frame_dones = 0;
    exp_q.delete();
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("count_cleared_on_start", 64'(pix_count), 64'(0));
    chk("err_cleared_on_start", 64'(err_range), 64'(0));
  endtask

  task automatic send(input logic [IW-1:0] idx, input logic [31:0] data);
    pix_valid = 1'b1;
    pix_index = idx;
    pix_data  = data;
    for (int n = 0; n < 100 && pix_ready !== 1'b1; n++) tick();
    n_checks++;
    if (pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: pix_ready=%b for index %0d, expected 1", pix_ready, idx);
    end else begin
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    pix_valid          = 1'b0;
    master_waitrequest = 1'b0;
    for (int n = 0; n < 200 && frame_done !== 1'b1; n++) tick();
    chk({name, "_frame_done"}, 64'(frame_done), 64'(1));
    chk({name, "_busy_in_done"}, 64'(busy), 64'(1));
    tick();
    chk({name, "_done_one_cycle"}, 64'(frame_done), 64'(0));
    chk({name, "_busy_falls"}, 64'(busy), 64'(0));
    chk({name, "_done_count"}, 64'(frame_dones), 64'(1));
    chk({name, "_pix_count"}, 64'(pix_count), 64'(exp_count));
    chk({name, "_err_range"}, 64'(err_range), 64'(exp_err));
    chk({name, "_writes_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_pix_ready"}, 64'(pix_ready), 64'(0));
    chk({name, "_master_write"}, 64'(master_write), 64'(0));
    chk({name, "_address"}, 64'(master_address), 64'(0));
    chk({name, "_writedata"}, 64'(master_writedata), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_frame_done"}, 64'(frame_done), 64'(0));
    chk({name, "_err_range"}, 64'(err_range), 64'(0));
    chk({name, "_pix_count"}, 64'(pix_count), 64'(0));
  endtask

  initial begin
    vec_t          v;
    int            sent;
    logic [IW-1:0] ridx;
    logic [31:0]   rdata;

    for (int i = 0; i < 8; i++) begin
      vt[i].idx      = IW'(i);
      vt[i].data     = 32'h10 + 32'(i);
      vt[i].exp_wr   = 1'b1;
      vt[i].exp_addr = BASE + 32'(4 * i);
      vt[i].exp_err  = 1'b0;
      vt[8+i].idx      = IW'(idx3[i]);
      vt[8+i].data     = 32'h40 + 32'(i);
      vt[8+i].exp_wr   = (idx3[i] < NP);
      vt[8+i].exp_addr = BASE + 32'(4 * idx3[i]);
      vt[8+i].exp_err  = (i >= 1);
    end

    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_index = '0; pix_data = '0;
    master_waitrequest = 1'b0; stall_prev = 1'b0;
    exp_count = 0; exp_err = 1'b0; frame_dones = 0;
    repeat (2) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    chk("idle_ready", 64'(pix_ready), 64'(0));

    // Basic frame then range-error frame, both from the vector table.
    for (int f = 0; f < 2; f++) begin
      start_frame();
      for (int i = 0; i < 8; i++) begin
        v = vt[f*8+i];
        pix_valid = 1'b1;
        pix_index = v.idx;
        pix_data  = v.data;
        chk("vec_ready", 64'(pix_ready), 64'(1));
        tick();
        chk("vec_pix_count", 64'(pix_count), 64'(i + 1));
        chk("vec_err_range", 64'(err_range), 64'(v.exp_err));
        chk("vec_master_write", 64'(master_write), 64'(v.exp_wr));
        if (v.exp_wr) begin
          chk("vec_address", 64'(master_address), 64'(v.exp_addr));
          chk("vec_writedata", 64'(master_writedata), 64'(v.data));
        end
      end
      wait_done(f == 0 ? "basic" : "range");
    end
    chk("err_held_in_idle", 64'(err_range), 64'(1));

    // Start after DONE clears status; start mid-frame is ignored.
    start_frame();
    for (int i = 0; i < 3; i++) send(IW'(i), 32'h200 + 32'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midframe_start_count", 64'(pix_count), 64'(3));
    chk("midframe_start_busy", 64'(busy), 64'(1));
    for (int i = 3; i < 8; i++) send(IW'(i), 32'h200 + 32'(i));
    wait_done("restart_ignored");

    // Backpressure: FIFO fills, bus holds, then a pop while full.
    start_frame();
    master_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) send(IW'(i), 32'h100 + 32'(i));
    pix_valid = 1'b1; pix_index = IW'(4); pix_data = 32'h104;
    chk("ready_drops_when_full", 64'(pix_ready), 64'(0));
    chk("count_at_full", 64'(pix_count), 64'(4));
    repeat (20) tick();
    chk("stalled_head_addr", 64'(master_address), 64'(BASE));
    chk("stalled_head_data", 64'(master_writedata), 64'(32'h100));
    chk("ready_still_low", 64'(pix_ready), 64'(0));
    master_waitrequest = 1'b0;
    chk("ready_in_pop_cycle", 64'(pix_ready), 64'(0));
    tick();
    chk("ready_after_pop", 64'(pix_ready), 64'(1));
    for (int i = 4; i < 8; i++) send(IW'(i), 32'h100 + 32'(i));
    wait_done("backpressure");

    // Reset with three entries stalled in the FIFO.
    start_frame();
    master_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) send(IW'(i), 32'h300 + 32'(i));
    chk("stalled_before_reset", 64'(master_write), 64'(1));
    reset = 1'b1;
    tick();
    check_reset_values("midstall_reset");
    reset = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    master_waitrequest = 1'b0;
    tick();
    start_frame();
    for (int i = 0; i < 8; i++) send(IW'(7 - i), $urandom);
    wait_done("after_reset");

    // Random traffic against the queue model: gaps, stalls, repeats and stray indices.
    for (int f = 0; f < 2; f++) begin
      start_frame();
      sent  = 0;
      ridx  = IW'($urandom_range(0, 9));
      rdata = $urandom;
      for (int n = 0; n < 600 && sent < 8; n++) begin
        pix_valid          = ($urandom_range(0, 3) != 0);
        master_waitrequest = ($urandom_range(0, 2) == 0);
        pix_index          = ridx;
        pix_data           = rdata;
        if (pix_valid && pix_ready === 1'b1) begin
          sent++;
          ridx  = IW'($urandom_range(0, 9));
          rdata = $urandom;
        end
        tick();
      end
      chk("random_all_sent", 64'(sent), 64'(8));
      wait_done("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
